// File: rtl/addsub_acc_ctrl.sv
// Command-driven accumulator wrapper around an external combinational WIDTH-bit add/sub unit.
// Latency: command accepted in IDLE, one EXEC cycle, then the result is held in RESP (3-cycle best throughput).
// Backpressure: cmd_ready only in IDLE; RESP holds res_data/res_ov stable until res_ready is seen.
module addsub_acc_ctrl #(
  parameter int WIDTH = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_op,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_ov,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_ov,
  output logic             ov_sticky,
  output logic [WIDTH-1:0] acc
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Saturation limits: largest positive and most negative two's complement values.
  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_ov_q, res_ov_d;
  logic             ov_sticky_q, ov_sticky_d;

  logic [WIDTH-1:0] arith_res;

  // Arithmetic result: wrapped sum, or clamped toward the sign of the accumulator on overflow.
  always_comb begin
    arith_res = add_sum;
    if (SAT && add_ov) begin
      arith_res = acc_q[WIDTH-1] ? SAT_NEG : SAT_POS;
    end
  end

  // Next-state logic for the FSM and all datapath registers.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    res_data_d  = res_data_q;
    res_ov_d    = res_ov_q;
    ov_sticky_d = ov_sticky_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          opnd_d  = cmd_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (op_q)
          OP_LOAD: begin
            acc_d    = opnd_q;
            res_ov_d = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            acc_d       = arith_res;
            res_ov_d    = add_ov;
            ov_sticky_d = ov_sticky_q | add_ov;
          end
          OP_CLR: begin
            acc_d       = '0;
            res_ov_d    = 1'b0;
            ov_sticky_d = 1'b0;
          end
          default: ;
        endcase
        res_data_d = acc_d;
        state_d    = RESP;
      end
      RESP: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= OP_LOAD;
      res_data_q  <= '0;
      res_ov_q    <= 1'b0;
      ov_sticky_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      res_data_q  <= res_data_d;
      res_ov_q    <= res_ov_d;
      ov_sticky_q <= ov_sticky_d;
    end
  end

  // Adder inputs come only from registers, so cmd_* never reaches the add/sub unit combinationally.
  assign add_a  = acc_q;
  assign add_b  = opnd_q;
  assign add_op = (op_q == OP_SUB);

  // Handshake outputs decode the state register; cmd_ready is also held low while in reset.
  assign cmd_ready = (state_q == IDLE) && !rst;
  assign res_valid = (state_q == RESP);
  assign res_data  = res_data_q;
  assign res_ov    = res_ov_q;
  assign ov_sticky = ov_sticky_q;
  assign acc       = acc_q;

endmodule
